// File: rtl/cpu_port_io.sv
// Peripheral side of the CPU's 8-bit I/O ports. s0/s1 carry a toggle-handshake command stream into
// a TX FIFO drained by a valid/ready sink. An RX FIFO filled by a valid/ready source is read through e0/e1.
module cpu_port_io #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] s0,
   input  logic [7:0] s1,
   output logic [7:0] e0,
   output logic [7:0] e1,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready
);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [7:0]    s0_q, s1_q, s1_prev_q;
   logic [7:0]    tx_mem_q [DEPTH];
   logic [7:0]    rx_mem_q [DEPTH];
   logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic          tx_ack_q, tx_ack_d, rx_ack_q, rx_ack_d;
   logic          tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;

   logic flush, tx_evt, rx_evt;
   logic tx_full, tx_empty, rx_full, rx_empty;
   logic tx_drain, tx_push, rx_fill, rx_pop;
   logic s1_unused;

   assign s1_unused = ^{s1_q[6:2], s1_prev_q[7:2]};

   // Flush is a level on s1[7]; while it is high, toggle events are swallowed without an ack.
   assign flush  = s1_q[7];
   assign tx_evt = (s1_q[0] ^ s1_prev_q[0]) & ~flush;
   assign rx_evt = (s1_q[1] ^ s1_prev_q[1]) & ~flush;

   assign tx_full  = (tx_cnt_q == FULL);
   assign tx_empty = (tx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == FULL);
   assign rx_empty = (rx_cnt_q == '0);

   assign tx_valid = ~tx_empty & ~flush;
   assign tx_data  = tx_valid ? tx_mem_q[tx_rp_q] : 8'h00;
   assign rx_ready = ~rx_full & ~flush;
   assign e0       = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
   assign e1       = {rx_unf_q, tx_ovf_q, rx_empty, rx_full, tx_empty, tx_full, rx_ack_q, tx_ack_q};

   // A full TX FIFO still takes a push when the sink drains at the same edge.
   assign tx_drain = tx_valid & tx_ready;
   assign tx_push  = tx_evt & (~tx_full | tx_drain);
   assign rx_fill  = rx_valid & rx_ready;
   assign rx_pop   = rx_evt & ~rx_empty;

   always_comb begin
      tx_wp_d  = tx_wp_q + AW'(tx_push);
      tx_rp_d  = tx_rp_q + AW'(tx_drain);
      rx_wp_d  = rx_wp_q + AW'(rx_fill);
      rx_rp_d  = rx_rp_q + AW'(rx_pop);
      tx_cnt_d = tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_drain);
      rx_cnt_d = rx_cnt_q + (AW+1)'(rx_fill) - (AW+1)'(rx_pop);
      tx_ack_d = tx_ack_q ^ tx_evt;
      rx_ack_d = rx_ack_q ^ rx_evt;
      tx_ovf_d = tx_ovf_q | (tx_evt & ~tx_push);
      rx_unf_d = rx_unf_q | (rx_evt & rx_empty);
      if (flush) begin
         tx_wp_d  = '0;
         tx_rp_d  = '0;
         rx_wp_d  = '0;
         rx_rp_d  = '0;
         tx_cnt_d = '0;
         rx_cnt_d = '0;
         tx_ovf_d = 1'b0;
         rx_unf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s0_q      <= '0;
         s1_q      <= '0;
         s1_prev_q <= '0;
         tx_wp_q   <= '0;
         tx_rp_q   <= '0;
         rx_wp_q   <= '0;
         rx_rp_q   <= '0;
         tx_cnt_q  <= '0;
         rx_cnt_q  <= '0;
         tx_ack_q  <= 1'b0;
         rx_ack_q  <= 1'b0;
         tx_ovf_q  <= 1'b0;
         rx_unf_q  <= 1'b0;
      end else begin
         s0_q      <= s0;
         s1_q      <= s1;
         s1_prev_q <= s1_q;
         tx_wp_q   <= tx_wp_d;
         tx_rp_q   <= tx_rp_d;
         rx_wp_q   <= rx_wp_d;
         rx_rp_q   <= rx_rp_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_cnt_q  <= rx_cnt_d;
         tx_ack_q  <= tx_ack_d;
         rx_ack_q  <= rx_ack_d;
         tx_ovf_q  <= tx_ovf_d;
         rx_unf_q  <= rx_unf_d;
      end
   end

   // Storage carries no reset; validity is tracked solely by the counts.
   always_ff @(posedge clk) begin
      if (reset && tx_push) tx_mem_q[tx_wp_q] <= s0_q;
      if (reset && rx_fill) rx_mem_q[rx_wp_q] <= rx_data;
   end
endmodule
